// File: rtl/kbd_ctrl.sv
// PS/2 keyboard controller: it tracks the F0/E0 prefixes and the modifier state, looks up
// ASCII codes, and buffers key events in a FIFO that the CPU reads over the peripheral bus.
module kbd_ctrl #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic              scan_ready,
    input  logic [7:0]        scancode,
    output logic [8:0]        lut_addr,
    input  logic [7:0]        lut_data,
    output logic              irq
);

    localparam int unsigned DEPTH   = 2 ** DEPTH_LOG2;
    localparam int unsigned CNT_W   = DEPTH_LOG2 + 1;
    localparam int unsigned ENTRY_W = 22;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam logic [7:0] CODE_BREAK  = 8'hF0;
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CTRL   = 8'h14;
    localparam logic [7:0] CODE_ALT    = 8'h11;
    localparam logic [7:0] CODE_CAPS   = 8'h58;

    logic keyup_p, ext_p;
    logic mod_shift, mod_ctrl, mod_alt, mod_caps, caps_held;
    logic shift_n, ctrl_n, alt_n, caps_n, caps_held_n;
    logic ev_valid, ev_keyup, ev_ext;
    logic [7:0] ev_code;
    logic keyup_en, raw_en, irq_en, overflow;

    logic [DEPTH_LOG2-1:0] head, tail;
    logic [CNT_W-1:0]      count;
    logic [ENTRY_W-1:0]    mem [DEPTH];

    logic       evt_c, rd_c, wr_c, pop_c, push_req_c, push_c, ovf_set_c;
    logic       flush_c, clr_ovf_c, full_c, empty_c;
    logic [1:0] reg_sel;
    logic [ENTRY_W-1:0] entry_c;
    logic unused_bits;

    assign reg_sel  = addr[3:2];
    assign rd_c     = ena & ~rw;
    assign wr_c     = ena & rw;
    assign evt_c    = scan_ready && (scancode != CODE_BREAK) && (scancode != CODE_EXT);
    assign lut_addr = {mod_shift ^ mod_caps, scancode};

    assign unused_bits = ^{addr[ADDR_W-1:4], addr[1:0], wdata[DATA_W-1:5]};

    // Modifier next-state for the byte that completes an event
    always_comb begin
        shift_n     = mod_shift;
        ctrl_n      = mod_ctrl;
        alt_n       = mod_alt;
        caps_n      = mod_caps;
        caps_held_n = caps_held;
        if (evt_c) begin
            case (scancode)
                CODE_LSHIFT, CODE_RSHIFT: shift_n = ~keyup_p;
                CODE_CTRL:                ctrl_n  = ~keyup_p;
                CODE_ALT:                 alt_n   = ~keyup_p;
                CODE_CAPS: begin
                    if (keyup_p) begin
                        caps_held_n = 1'b0;
                    end else begin
                        // Typematic repeats arrive with caps_held set and do not re-toggle
                        if (!caps_held) caps_n = ~mod_caps;
                        caps_held_n = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Prefix tracking, modifier state, and the one-stage event pipeline that waits for lut_data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            keyup_p   <= 1'b0;
            ext_p     <= 1'b0;
            mod_shift <= 1'b0;
            mod_ctrl  <= 1'b0;
            mod_alt   <= 1'b0;
            mod_caps  <= 1'b0;
            caps_held <= 1'b0;
            ev_valid  <= 1'b0;
            ev_keyup  <= 1'b0;
            ev_ext    <= 1'b0;
            ev_code   <= 8'h00;
        end else begin
            mod_shift <= shift_n;
            mod_ctrl  <= ctrl_n;
            mod_alt   <= alt_n;
            mod_caps  <= caps_n;
            caps_held <= caps_held_n;
            ev_valid  <= evt_c;
            if (scan_ready) begin
                if (scancode == CODE_BREAK) begin
                    keyup_p <= 1'b1;
                end else if (scancode == CODE_EXT) begin
                    ext_p <= 1'b1;
                end else begin
                    ev_code  <= scancode;
                    ev_keyup <= keyup_p;
                    ev_ext   <= ext_p;
                    keyup_p  <= 1'b0;
                    ext_p    <= 1'b0;
                end
            end
        end
    end

    // Modifier registers already hold post-update values in the capture cycle
    assign entry_c = {mod_caps, mod_alt, mod_ctrl, mod_shift, ev_keyup, ev_ext, ev_code, lut_data};

    assign full_c     = (count == CNT_W'(DEPTH));
    assign empty_c    = (count == '0);
    assign flush_c    = wr_c && (reg_sel == REG_CTRL) && wdata[3];
    assign clr_ovf_c  = wr_c && (reg_sel == REG_CTRL) && wdata[4];
    assign pop_c      = rd_c && (reg_sel == REG_DATA) && !empty_c;
    assign push_req_c = ev_valid && (!ev_keyup || keyup_en) && ((lut_data != 8'h00) || raw_en);
    assign push_c     = push_req_c && (!full_c || pop_c) && !flush_c;
    assign ovf_set_c  = push_req_c && full_c && !pop_c && !flush_c;

    // Control bits and the sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            keyup_en <= 1'b0;
            raw_en   <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_c && (reg_sel == REG_CTRL)) begin
                keyup_en <= wdata[0];
                raw_en   <= wdata[1];
                irq_en   <= wdata[2];
            end
            overflow <= (overflow & ~clr_ovf_c) | ovf_set_c;
        end
    end

    // FIFO storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push_c) mem[tail] <= entry_c;
    end

    // FIFO pointers and occupancy; flush overrides any push or pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_c) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_c) tail <= tail + DEPTH_LOG2'(1);
            if (pop_c)  head <= head + DEPTH_LOG2'(1);
            count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // Registered read data, zero whenever no read was issued in the previous cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (rd_c) begin
            case (reg_sel)
                REG_DATA:   rdata <= pop_c ? DATA_W'(mem[head]) : '0;
                REG_STATUS: rdata <= DATA_W'({mod_caps, mod_alt, mod_ctrl, mod_shift,
                                              overflow, full_c, empty_c, 8'(count)});
                REG_CTRL:   rdata <= DATA_W'({irq_en, raw_en, keyup_en});
                default:    rdata <= '0;
            endcase
        end else begin
            rdata <= '0;
        end
    end

    // Level interrupt from the registered occupancy and overflow state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) irq <= 1'b0;
        else      irq <= irq_en & (!empty_c | overflow);
    end

endmodule
